uart_tx_stream: RTL

UART transmit path: drains a 512x8 TX buffer BRAM and serializes it onto the `tx` pin as 8N1 frames, LSB first, at 115200 baud from a 24 MHz `clk`. It is the transmit counterpart of the UART RX FIFO writer. A host writes bytes into the TX BRAM, programs a length and pulses start; this block reads addresses 0..len-1 and raises a sticky done flag when the last stop bit completes. The done flag is cleared by an ack.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_stream_if.sv | 25 ++
 rtl/uart_tx_baud.sv | 46 ++++
 rtl/uart_tx_stream.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing for the UART transmit path.
// Depth/address width of the TX buffer and default baud divider settings.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 512;
  localparam int UART_FIFO_AW    = 9;
  localparam int UART_CLK_DIV    = 13;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } uart_tx_state_t;

  function automatic logic [9:0] uart_clamp_len(input logic [9:0] len);
    return (len > 10'(UART_FIFO_DEPTH)) ? 10'(UART_FIFO_DEPTH) : len;
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Host control and TX-buffer read port of uart_tx_stream.
// master = host/BRAM side, slave = the transmitter.
interface uart_tx_stream_if;
  import uart_pkg::*;

  logic                    tx_start;
  logic [9:0]              tx_len;
  logic                    tx_done_ack;
  logic [7:0]              tx_fifo_rd;
  logic [UART_FIFO_AW-1:0] tx_fifo_ra;
  logic                    tx_fifo_ren;
  logic                    tx_busy;
  logic                    tx_done;

  modport master (
    output tx_start, tx_len, tx_done_ack, tx_fifo_rd,
    input  tx_fifo_ra, tx_fifo_ren, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_len, tx_done_ack, tx_fifo_rd,
    output tx_fifo_ra, tx_fifo_ren, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx_baud.sv
// Bit-period tick generator: single-cycle bit_end every CLK_DIV*OVERSAMPLE clk.
// restart synchronously zeroes both counters so the next period starts fresh.
module uart_tx_baud #(
  parameter int CLK_DIV    = 13,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_end
);

  localparam int DW = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
  localparam int OW = ($clog2(OVERSAMPLE) < 1) ? 1 : $clog2(OVERSAMPLE);

  logic [DW-1:0] div_q, div_d;
  logic [OW-1:0] os_q, os_d;
  logic          tick;

  always_comb begin
    tick    = (div_q == DW'(CLK_DIV - 1));
    bit_end = tick && (os_q == OW'(OVERSAMPLE - 1));
    div_d   = div_q;
    os_d    = os_q;
    if (restart) begin
      div_d = '0;
      os_d  = '0;
    end else if (tick) begin
      div_d = '0;
      os_d  = bit_end ? '0 : os_q + OW'(1);
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      os_q  <= '0;
    end else begin
      div_q <= div_d;
      os_q  <= os_d;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Streams tx_len bytes from the TX BRAM onto tx as 8N1 frames, LSB first; sticky tx_done until acked.
// Define UART_TX_TWO_STOP_EN for two stop bits; the next byte is prefetched during STOP for gapless frames.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_stream_if.slave   bus,
  output logic              tx
);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic STOP_LAST = 1'b1;
`else
  localparam logic STOP_LAST = 1'b0;
`endif

  uart_tx_state_t          state_q, state_d;
  logic [9:0]              len_q, len_d;
  logic [9:0]              idx_q, idx_d, idx_next;
  logic [7:0]              shift_q, shift_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic                    pf_q, pf_d;
  logic                    tx_q, tx_d;
  logic                    ren_q, ren_d;
  logic [UART_FIFO_AW-1:0] ra_q, ra_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    baud_restart;
  logic                    bit_end;

  // Counters sit at zero outside the frame, so START always gets a full first bit.
  assign baud_restart = !(state_q inside {ST_START, ST_DATA, ST_STOP});

  uart_tx_baud #(
    .CLK_DIV    (CLK_DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (baud_restart),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    ren_d      = 1'b0;
    ra_d       = ra_q;
    idx_next   = idx_q + 10'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_start) begin
          if (bus.tx_len == 10'd0) begin
            state_d = ST_DONE;
          end else begin
            len_d   = uart_clamp_len(bus.tx_len);
            idx_d   = '0;
            ra_d    = '0;
            ren_d   = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = bus.tx_fifo_rd;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
            // Prefetch lands as ren in the first STOP cycle.
            if (idx_next < len_q) begin
              ren_d = 1'b1;
              ra_d  = idx_next[UART_FIFO_AW-1:0];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (pf_q) shift_d = bus.tx_fifo_rd;
        if (bit_end) begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = 1'b1;
          end else if (idx_next < len_q) begin
            idx_d   = idx_next;
            state_d = ST_START;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.tx_done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pf_d   = ren_q && (state_q == ST_STOP);
    tx_d   = (state_d == ST_START) ? 1'b0 :
             (state_d == ST_DATA)  ? shift_d[0] : 1'b1;
    busy_d = !(state_d inside {ST_IDLE, ST_DONE});
    // Done shows one cycle after the final stop ends; a zero-length start flags at once.
    done_d = (state_d == ST_DONE) && (state_q inside {ST_DONE, ST_IDLE});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pf_q       <= 1'b0;
      tx_q       <= 1'b1;
      ren_q      <= 1'b0;
      ra_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      pf_q       <= pf_d;
      tx_q       <= tx_d;
      ren_q      <= ren_d;
      ra_q       <= ra_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx              = tx_q;
  assign bus.tx_fifo_ren = ren_q;
  assign bus.tx_fifo_ra  = ra_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;

endmodule
